// File: rtl/gfg_development_tros.sv
// gfg_development_tros: gated edge-counting frequency meter (Tiny Tapeout tile top).
// Counts rising edges of ui_in[0] over a 2^(GATE_MIN+sel) clock window, latches the
// count into a result register and shows it on a 7-segment digit and the bidir bus.
// Optional build macro: TROS_SELFTEST_EN adds an internal clk/2 source selectable
// through uio_in[0] in place of the external pin.
module gfg_development_tros #(
    parameter int CNT_W    = 16,
    parameter int GATE_MIN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int TW = GATE_MIN + 8;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        LATCH
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [CNT_W-1:0]   result_q, result_d;
    logic               valid_q, valid_d;

    logic               sync1_q, sync2_q, sync3_q;
    logic               src;
    logic               pulse;
    logic               go;
    logic [31:0]        win_len;
    logic [TW-1:0]      last_cnt;
    logic [15:0]        res16;
    logic [3:0]         nibble;
    logic [6:0]         seg;

`ifdef TROS_SELFTEST_EN
    logic               tog_q;
    logic               unused_uio;

    // Free-running clk/2 reference for the self-test source
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tog_q <= 1'b0;
        end else begin
            tog_q <= ~tog_q;
        end
    end

    assign src        = uio_in[0] ? tog_q : ui_in[0];
    assign unused_uio = &{1'b0, uio_in[7:1]};
`else
    logic               unused_uio;

    assign src        = ui_in[0];
    assign unused_uio = &{1'b0, uio_in};
`endif

    // Two-flop synchronizer plus one extra stage for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= src;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign pulse    = sync2_q & ~sync3_q;
    assign go       = ui_in[6] & ena;
    assign win_len  = 32'd1 << (GATE_MIN + int'(sel_q));
    assign last_cnt = TW'(win_len - 32'd1);

    // Gate-window FSM state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            timer_q   <= '0;
            counter_q <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            timer_q   <= timer_d;
            counter_q <= counter_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
        end
    end

    // Next-state logic: window timing, saturating count, latch and abort
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        timer_d   = timer_q;
        counter_d = counter_q;
        result_d  = result_q;
        valid_d   = valid_q;
        case (state_q)
            IDLE: begin
                counter_d = '0;
                timer_d   = '0;
                if (go) begin
                    state_d = COUNT;
                    sel_d   = ui_in[3:1];
                end
            end
            COUNT: begin
                if (!go) begin
                    state_d   = IDLE;
                    counter_d = '0;
                    timer_d   = '0;
                end else begin
                    if (pulse && (counter_q != '1)) begin
                        counter_d = counter_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    if (timer_q == last_cnt) begin
                        state_d = LATCH;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
            end
            LATCH: begin
                result_d  = counter_q;
                valid_d   = 1'b1;
                counter_d = '0;
                timer_d   = '0;
                if (go) begin
                    state_d = COUNT;
                    sel_d   = ui_in[3:1];
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign res16  = 16'(result_q);
    assign nibble = res16[{ui_in[5:4], 2'b00} +: 4];

    // Hex nibble to segments a..g (bit0 = a, active-high)
    always_comb begin
        seg = 7'h00;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

    assign uo_out  = {valid_q, seg};
    assign uio_out = ui_in[7] ? res16[15:8] : res16[7:0];
    assign uio_oe  = '1;

endmodule

// File: tb/tb_gfg_development_tros.sv
// Testbench for gfg_development_tros: a 16-bit and an 8-bit counter build share the
// same stimulus; a window-level model predicts every latched result from the pin history.
module tb_gfg_development_tros;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:1] ctrl;
    logic       pin;
    logic       man_pin;
    logic       wave_q;
    logic       wcnt;
    int         mode;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;
    logic [7:0] uo_out8, uio_out8, uio_oe8;

    int checks;
    int errors;

    localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    assign ui_in = {ctrl, pin};
    assign pin   = (mode == 0) ? man_pin : wave_q;

    gfg_development_tros dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    gfg_development_tros #(.CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out8),
        .uio_in(uio_in), .uio_out(uio_out8), .uio_oe(uio_oe8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Square-wave source: mode 1 toggles every 2 clk, mode 2 every clk
    initial begin
        wave_q = 1'b0;
        wcnt   = 1'b0;
    end
    always @(negedge clk) begin
        if (mode == 1) begin
            if (wcnt) begin
                wave_q = ~wave_q;
                wcnt   = 1'b0;
            end else begin
                wcnt = 1'b1;
            end
        end else if (mode == 2) begin
            wave_q = ~wave_q;
        end
    end

    // ---------------- window-level model ----------------
    bit          hist [0:65535];
    int unsigned cyc;
    logic [15:0] m_res16;
    logic [7:0]  m_res8;
    logic        m_valid;
    int          m_latches;
    bit          m_active;
    int unsigned m_start;
    int unsigned m_w;
    int unsigned m_off;
    int          m_total;
    logic        m_src;
`ifdef TROS_SELFTEST_EN
    logic        tb_tog;
    initial tb_tog = 1'b0;
`endif

    initial begin
        cyc = 0; m_res16 = '0; m_res8 = '0; m_valid = 1'b0; m_latches = 0;
        m_active = 1'b0; m_start = 0; m_w = 0;
    end

    // A rising edge of the source first seen at edge k-2 is counted at edge k
    function automatic int pls(input int unsigned k);
        if (k < 3) return 0;
        return (hist[k-2] && !hist[k-3]) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        cyc   = cyc + 1;
        m_src = pin;
`ifdef TROS_SELFTEST_EN
        if (uio_in[0]) m_src = tb_tog;
        tb_tog = rst_n ? ~tb_tog : 1'b0;
`endif
        if (cyc < 65536) hist[cyc] = m_src;
        if (!rst_n) begin
            m_res16 = '0; m_res8 = '0; m_valid = 1'b0; m_active = 1'b0;
        end else if (!m_active) begin
            if (ui_in[6] && ena) begin
                m_active = 1'b1;
                m_start  = cyc;
                m_w      = 1 << (8 + int'(ui_in[3:1]));
            end
        end else begin
            m_off = cyc - m_start;
            if (m_off <= m_w) begin
                if (!(ui_in[6] && ena)) m_active = 1'b0;
            end else begin
                m_total = 0;
                for (int unsigned k = m_start + 1; k <= m_start + m_w; k++) m_total += pls(k);
                m_res16 = (m_total > 65535) ? 16'hFFFF : 16'(m_total);
                m_res8  = (m_total > 255) ? 8'hFF : 8'(m_total);
                m_valid = 1'b1;
                m_latches++;
                if (ui_in[6] && ena) begin
                    m_start = cyc;
                    m_w     = 1 << (8 + int'(ui_in[3:1]));
                end else begin
                    m_active = 1'b0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_uo(input logic [15:0] r, input logic v, input logic [1:0] s);
        int n;
        n = (int'(r) / (1 << (4 * int'(s)))) % 16;
        return {v, SEG[n]};
    endfunction

    task automatic compare_loop();
        logic [15:0] r8;
        forever begin
            @(posedge clk);
            #3;
            chk("uo_out", {8'h00, uo_out}, {8'h00, exp_uo(m_res16, m_valid, ctrl[5:4])});
            chk("uio_out", {8'h00, uio_out}, {8'h00, ctrl[7] ? m_res16[15:8] : m_res16[7:0]});
            chk("uio_oe", {8'h00, uio_oe}, 16'h00FF);
            r8 = {8'h00, m_res8};
            chk("uo_out8", {8'h00, uo_out8}, {8'h00, exp_uo(r8, m_valid, ctrl[5:4])});
            chk("uio_out8", {8'h00, uio_out8}, {8'h00, ctrl[7] ? r8[15:8] : r8[7:0]});
            chk("uio_oe8", {8'h00, uio_oe8}, 16'h00FF);
        end
    endtask

    task automatic wait_latch(input int n, input int budget);
        int target;
        bit hit;
        target = m_latches + n;
        hit    = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (m_latches >= target) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL latch_timeout: got %0d latches expected %0d", m_latches, target);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; ena = 1'b1; ctrl = '0; mode = 0; man_pin = 1'b0; uio_in = 8'hFE;
        fork
            compare_loop();
        join_none

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_uo", {8'h00, uo_out}, 16'h003F);
        chk("rst_uio", {8'h00, uio_out}, 16'h0000);
        chk("rst_oe", {8'h00, uio_oe}, 16'h00FF);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("idle_uo", {8'h00, uo_out}, 16'h003F);
        chk("idle_uio", {8'h00, uio_out}, 16'h0000);

        // basic count: period-4 wave, sel 0 -> 64
        mode = 1;
        repeat (10) @(negedge clk);
        ctrl[3:1] = 3'd0; ctrl[5:4] = 2'd1; ctrl[7] = 1'b0; ctrl[6] = 1'b1;
        wait_latch(1, 400);
        #1;
        chk("basic_byte", {8'h00, uio_out}, 16'h0040);
        chk("basic_seg", {8'h00, uo_out}, 16'h00E6);
        chk("basic_byte8", {8'h00, uio_out8}, 16'h0040);

        // abort mid-window: result and flag hold
        repeat (100) @(negedge clk);
        ctrl[6] = 1'b0;
        repeat (300) @(negedge clk);
        #1;
        chk("abort_byte", {8'h00, uio_out}, 16'h0040);
        chk("abort_seg", {8'h00, uo_out}, 16'h00E6);

        // gate scaling: sel 3 -> 512; 8-bit build saturates
        ctrl[3:1] = 3'd3; ctrl[5:4] = 2'd2; ctrl[7] = 1'b1; ctrl[6] = 1'b1;
        wait_latch(1, 2200);
        #1;
        chk("gate_hi", {8'h00, uio_out}, 16'h0002);
        chk("gate_seg", {8'h00, uo_out}, 16'h00DB);
        ctrl[7] = 1'b0;
        #1;
        chk("gate_lo", {8'h00, uio_out}, 16'h0000);
        chk("sat8_byte", {8'h00, uio_out8}, 16'h00FF);
        chk("sat8_seg", {8'h00, uo_out8}, 16'h00BF);

        // ena low aborts, then full-rate wave with sel 7 -> 16384
        @(negedge clk);
        ena  = 1'b0;
        mode = 2;
        repeat (20) @(negedge clk);
        ctrl[3:1] = 3'd7; ctrl[5:4] = 2'd3; ctrl[7] = 1'b1; ena = 1'b1;
        wait_latch(1, 33000);
        #1;
        chk("max_hi", {8'h00, uio_out}, 16'h0040);
        chk("max_seg", {8'h00, uo_out}, 16'h00E6);
        ctrl[7] = 1'b0;
        #1;
        chk("max_lo", {8'h00, uio_out}, 16'h0000);
        chk("max_byte8", {8'h00, uio_out8}, 16'h00FF);

        // window boundaries: edge on last COUNT cycle counted, on LATCH dropped
        @(negedge clk);
        ctrl[6] = 1'b0; mode = 0; man_pin = 1'b0;
        repeat (10) @(negedge clk);
        ctrl[3:1] = 3'd0; ctrl[5:4] = 2'd0; ctrl[7] = 1'b0; ctrl[6] = 1'b1;
        repeat (254) @(negedge clk);
        man_pin = 1'b1;
        wait_latch(1, 50);
        #1;
        chk("last_cycle_byte", {8'h00, uio_out}, 16'h0001);
        chk("last_cycle_seg", {8'h00, uo_out}, 16'h0086);
        man_pin = 1'b0;
        repeat (254) @(negedge clk);
        man_pin = 1'b1;
        wait_latch(1, 50);
        #1;
        chk("latch_drop_byte", {8'h00, uio_out}, 16'h0000);
        chk("latch_drop_seg", {8'h00, uo_out}, 16'h00BF);
        wait_latch(1, 300);
        #1;
        chk("next_win_byte", {8'h00, uio_out}, 16'h0000);

`ifdef TROS_SELFTEST_EN
        // internal clk/2 source -> 128 per 256-cycle window
        @(negedge clk);
        ctrl[6] = 1'b0; man_pin = 1'b0;
        repeat (10) @(negedge clk);
        uio_in = 8'h01; ctrl[6] = 1'b1;
        wait_latch(2, 600);
        #1;
        chk("self_lo", {8'h00, uio_out}, 16'h0080);
        chk("self_lo8", {8'h00, uio_out8}, 16'h0080);
        ctrl[7] = 1'b1;
        #1;
        chk("self_hi", {8'h00, uio_out}, 16'h0000);
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
